// File: rtl/qoa_encoder.sv
// qoa_encoder: per-sample QOA encoder core (LMS predict, 3-bit quantize, decoder-exact reconstruct, LMS update); define QOA_ERR_EN to add out_err and lms_restore
module qoa_encoder #(
  parameter int LMS_TAPS = 4,
  parameter int HW_WIDTH = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [HW_WIDTH-1:0] in_sample,
  input  logic [3:0]                 in_sf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_qr,
  output logic signed [HW_WIDTH-1:0] out_recon,
  input  logic                       ld_en,
  input  logic                       ld_sel,
  input  logic [1:0]                 ld_idx,
  input  logic [HW_WIDTH-1:0]        ld_data,
  input  logic                       rd_sel,
  input  logic [1:0]                 rd_idx,
  output logic [HW_WIDTH-1:0]        rd_data
`ifdef QOA_ERR_EN
  ,
  output logic [31:0]                out_err,
  input  logic                       lms_restore
`endif
);
  typedef enum logic [2:0] {IDLE, PREDICT, QUANT, UPDATE, HOLD} state_t;
  localparam logic [16:0] RECIP [16] = '{17'd65536, 17'd9363, 17'd3121, 17'd1457, 17'd781, 17'd475, 17'd311, 17'd216,
                                         17'd156, 17'd117, 17'd90, 17'd71, 17'd57, 17'd47, 17'd39, 17'd32};
  localparam logic [15:0] SF_TAB [16] = '{16'd1, 16'd7, 16'd21, 16'd45, 16'd84, 16'd138, 16'd211, 16'd304,
                                          16'd421, 16'd562, 16'd731, 16'd928, 16'd1157, 16'd1419, 16'd1715, 16'd2048};
  localparam logic [2:0] QUANT_TAB [17] = '{3'd7, 3'd7, 3'd7, 3'd5, 3'd5, 3'd3, 3'd3, 3'd1, 3'd0,
                                            3'd0, 3'd2, 3'd2, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6};
  state_t state, state_n;
  logic signed [HW_WIDTH-1:0] hist [LMS_TAPS];
  logic signed [HW_WIDTH-1:0] wts [LMS_TAPS];
  logic signed [31:0] acc;
  logic [1:0] tap;
  logic signed [15:0] samp;
  logic [3:0] sf;
  logic signed [18:0] p_c, p_r;
  logic signed [17:0] r_c;
  logic signed [35:0] nm;
  logic signed [19:0] n0, n_c, n_cl, sum;
  logic [2:0] qr_c, qr_r;
  logic [15:0] mag;
  logic signed [15:0] dq, delta, recon_c;
`ifdef QOA_ERR_EN
  logic signed [HW_WIDTH-1:0] hist_s [LMS_TAPS];
  logic signed [HW_WIDTH-1:0] wts_s [LMS_TAPS];
  logic signed [16:0] err_c;
`endif
  // state register
  always_ff @(posedge sys_clk) state <= sys_rst ? IDLE : state_n;
  // sequencing: accept in IDLE, four MAC taps, quantize, update, hold until taken
  always_comb begin
    state_n = (state == IDLE) ? (in_valid ? PREDICT : IDLE) :
              (state == PREDICT) ? ((tap == 2'd3) ? QUANT : PREDICT) :
              (state == QUANT) ? UPDATE :
              (state == UPDATE) ? HOLD :
              (out_ready ? IDLE : HOLD);
    in_ready = state == IDLE;
    out_valid = state == HOLD;
  end
  // quantizer and decoder-side reconstruction arithmetic
  always_comb begin
    p_c = 19'(acc >>> 13);
    r_c = {{2{samp[15]}}, samp} - p_c[17:0];
    nm = 36'(r_c) * 36'($signed({1'b0, RECIP[sf]})) + 36'sd32768;
    n0 = 20'(nm >>> 16);
    n_c = n0 + 20'(r_c > 18'sd0) - 20'(r_c < 18'sd0) - 20'(n0 > 20'sd0) + 20'(n0 < 20'sd0);
    n_cl = (n_c > 20'sd8) ? 20'sd8 : (n_c < -20'sd8) ? -20'sd8 : n_c;
    qr_c = QUANT_TAB[5'(n_cl + 20'sd8)];
    mag = (qr_r[2:1] == 2'd0) ? (16'd3 * SF_TAB[sf] + 16'd2) >> 2 :
          (qr_r[2:1] == 2'd1) ? (16'd5 * SF_TAB[sf] + 16'd1) >> 1 :
          (qr_r[2:1] == 2'd2) ? (16'd9 * SF_TAB[sf] + 16'd1) >> 1 : 16'd7 * SF_TAB[sf];
    dq = qr_r[0] ? -$signed(mag) : $signed(mag);
    sum = 20'(p_r) + 20'(dq);
    recon_c = (sum > 20'sd32767) ? 16'sh7fff : (sum < -20'sd32768) ? 16'sh8000 : sum[15:0];
    delta = dq >>> 4;
`ifdef QOA_ERR_EN
    err_c = 17'(samp) - 17'(recon_c);
`endif
  end
  // combinational LMS register readback
  always_comb rd_data = rd_sel ? wts[rd_idx] : hist[rd_idx];
  // datapath registers and LMS state
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < LMS_TAPS; i++) begin
        hist[i] <= '0;
        wts[i] <= '0;
`ifdef QOA_ERR_EN
        hist_s[i] <= '0;
        wts_s[i] <= '0;
`endif
      end
      acc <= '0;
      tap <= '0;
      samp <= '0;
      sf <= '0;
      p_r <= '0;
      qr_r <= '0;
      out_qr <= '0;
      out_recon <= '0;
`ifdef QOA_ERR_EN
      out_err <= '0;
`endif
    end else begin
      if (state == IDLE) begin
`ifdef QOA_ERR_EN
        if (lms_restore) begin
          hist <= hist_s;
          wts <= wts_s;
        end else
`endif
        if (ld_en && ld_sel) wts[ld_idx] <= ld_data;
        else if (ld_en) hist[ld_idx] <= ld_data;
        if (in_valid) begin
          samp <= in_sample;
          sf <= in_sf;
          acc <= '0;
          tap <= '0;
        end
      end
      if (state == PREDICT) begin
        acc <= acc + 32'(hist[tap]) * 32'(wts[tap]);
        tap <= tap + 2'd1;
`ifdef QOA_ERR_EN
        if (tap == 2'd0) begin
          hist_s <= hist;
          wts_s <= wts;
        end
`endif
      end
      if (state == QUANT) begin
        p_r <= p_c;
        qr_r <= qr_c;
      end
      if (state == UPDATE) begin
        for (int i = 0; i < LMS_TAPS; i++) wts[i] <= wts[i] + (hist[i][HW_WIDTH-1] ? -delta : delta);
        for (int i = 0; i < LMS_TAPS - 1; i++) hist[i] <= hist[i+1];
        hist[LMS_TAPS-1] <= recon_c;
        out_qr <= qr_r;
        out_recon <= recon_c;
`ifdef QOA_ERR_EN
        out_err <= 32'(err_c) * 32'(err_c);
`endif
      end
    end
  end
endmodule
